// File: rtl/frame_read_arbiter_pkg.sv
// Shared definitions for the inbound frame RAM read arbiter: state encoding
// and default frame RAM geometry.
package frame_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_OWNED = 2'd2
  } arb_state_e;

  localparam int FRAME_AW = 9;
  localparam int FRAME_DW = 9;
  localparam int FRAME_CW = 6;

  // Pointer width for an n-way round-robin; a 1-way picker still needs one bit.
  function automatic int rr_ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_read_arbiter_if.sv
// Producer/consumer/RAM-side bundle of the frame read arbiter.
// The master modport is the arbiter; the slave modport is its surroundings.
interface frame_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 9,
    parameter int CW      = 6
);
    logic                   frame_commit;
    logic [AW-1:0]          wr_ptr;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*AW-1:0]  cons_addr;
    logic [NUM_REQ-1:0]     cons_latch_tail;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     frame_start;
    logic [AW-1:0]          ram_raddr;
    logic                   data_valid;
    logic [AW-1:0]          frame_tail;
    logic [CW-1:0]          frame_count;
    logic                   overflow;

    modport master (
        input  frame_commit, wr_ptr, req, cons_addr, cons_latch_tail,
        output gnt, frame_start, ram_raddr, data_valid, frame_tail,
               frame_count, overflow
    );

    modport slave (
        output frame_commit, wr_ptr, req, cons_addr, cons_latch_tail,
        input  gnt, frame_start, ram_raddr, data_valid, frame_tail,
               frame_count, overflow
    );
endinterface

// File: rtl/frame_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping. Reusable by any N-way arbiter.
module frame_read_arbiter_rr_pick
    import frame_read_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = rr_ptr_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_oh,
    output logic [PW-1:0] o_idx,
    output logic          o_vld
);
    int w_c;

    // Scan offsets from farthest to nearest so the nearest hit lands last.
    always_comb begin
        o_oh  = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_c   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_c = (int'(i_ptr) + k) % N;
            if (i_req[w_c]) begin
                o_oh      = '0;
                o_oh[w_c] = 1'b1;
                o_idx     = PW'(w_c);
                o_vld     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/frame_read_arbiter.sv
// Owns the frame RAM read port: hands whole frames to one consumer at a time
// (round-robin), tracks the frame tail pointer and committed-frame count.
module frame_read_arbiter
    import frame_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = FRAME_AW,
    parameter int CW      = FRAME_CW
) (
    input logic                 clk,
    input logic                 rst_n,
    frame_read_arbiter_if.master bus
);
    localparam int PW = rr_ptr_w(NUM_REQ);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    arb_state_e          r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_fs;
    logic [PW-1:0]       r_win_idx;
    logic [PW-1:0]       r_rr_ptr;
    logic [AW-1:0]       r_tail;
    logic [CW-1:0]       r_count;
    logic                r_ovf;
    logic                r_dv;

    logic [NUM_REQ-1:0]  w_pick_oh;
    logic [PW-1:0]       w_pick_idx;
    logic                w_pick_vld;
    logic [AW-1:0]       w_win_addr;
    logic [AW-1:0]       w_raddr;
    logic [PW-1:0]       w_next_ptr;
    logic                w_done;
    logic                w_abort;
    logic                w_grant;

    frame_read_arbiter_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .i_req (bus.req),
        .i_ptr (r_rr_ptr),
        .o_oh  (w_pick_oh),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    assign w_win_addr = bus.cons_addr[int'(r_win_idx)*AW +: AW];
    assign w_raddr    = (r_state == ST_IDLE) ? r_tail : w_win_addr;
    assign w_next_ptr = (r_win_idx == PW'(NUM_REQ - 1)) ? '0 : r_win_idx + 1'b1;

    // Latch-tail from the owner beats a simultaneous req drop.
    assign w_done  = (r_state == ST_OWNED) && bus.cons_latch_tail[r_win_idx];
    assign w_abort = (r_state == ST_OWNED) && !bus.req[r_win_idx] && !w_done;
    assign w_grant = (r_state == ST_IDLE) && (r_count != '0) && w_pick_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_fs      <= '0;
            r_win_idx <= '0;
            r_rr_ptr  <= '0;
            r_tail    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_gnt     <= w_pick_oh;
                        r_fs      <= w_pick_oh;
                        r_win_idx <= w_pick_idx;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    r_fs    <= '0;
                    r_state <= ST_OWNED;
                end
                ST_OWNED: begin
                    if (w_done) begin
                        r_tail   <= w_win_addr;
                        r_rr_ptr <= w_next_ptr;
                        r_gnt    <= '0;
                        r_state  <= ST_IDLE;
                    end else if (w_abort) begin
                        // Tail and count untouched: the frame is re-offered.
                        r_rr_ptr <= w_next_ptr;
                        r_gnt    <= '0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_fs    <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (bus.frame_commit && !w_done) begin
            if (r_count == CNT_MAX) r_ovf <= 1'b1;
            else                    r_count <= r_count + 1'b1;
        end else if (!bus.frame_commit && w_done) begin
            r_count <= r_count - 1'b1;
        end
    end

    // RAM read data arrives one cycle after the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dv <= 1'b0;
        else        r_dv <= (r_gnt != '0) && (w_raddr != bus.wr_ptr);
    end

    assign bus.gnt         = r_gnt;
    assign bus.frame_start = r_fs;
    assign bus.ram_raddr   = w_raddr;
    assign bus.data_valid  = r_dv;
    assign bus.frame_tail  = r_tail;
    assign bus.frame_count = r_count;
    assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_frame_read_arbiter.sv
// Directed bench for frame_read_arbiter: grant, round-robin, completion,
// abort, count saturation, data_valid qualification and mid-frame reset.
module tb_frame_read_arbiter;
    localparam int N  = 4;
    localparam int AW = 9;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    frame_read_arbiter_if #(.NUM_REQ(N), .AW(AW), .CW(CW)) ifc ();

    frame_read_arbiter #(.NUM_REQ(N), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        ifc.cons_addr[i*AW +: AW] = a;
    endtask

    initial begin
        rst_n               = 1'b0;
        ifc.frame_commit    = 1'b0;
        ifc.wr_ptr          = 9'h1FF;
        ifc.req             = '0;
        ifc.cons_addr       = '0;
        ifc.cons_latch_tail = '0;
        set_addr(0, 9'h100);
        set_addr(1, 9'h010);
        set_addr(2, 9'h200);
        set_addr(3, 9'h300);
        repeat (3) tick();
        chk("rst_gnt",   ifc.gnt, 0);
        chk("rst_fs",    ifc.frame_start, 0);
        chk("rst_tail",  ifc.frame_tail, 0);
        chk("rst_count", ifc.frame_count, 0);
        chk("rst_ovf",   ifc.overflow, 0);
        chk("rst_dv",    ifc.data_valid, 0);
        rst_n = 1'b1;

        // 1: two commits, then consumers 1 and 2 request
        ifc.frame_commit = 1'b1;
        tick(); tick();
        ifc.frame_commit = 1'b0;
        chk("t1_count", ifc.frame_count, 2);
        chk("t1_idle_raddr", ifc.ram_raddr, 9'h000);
        ifc.req = 4'b0110;
        tick();
        chk("t1_gnt",   ifc.gnt, 4'b0010);
        chk("t1_fs",    ifc.frame_start, 4'b0010);
        chk("t1_raddr", ifc.ram_raddr, 9'h010);
        tick();
        chk("t1_fs_off", ifc.frame_start, 0);
        chk("t1_gnt_hold", ifc.gnt, 4'b0010);
        chk("t1_dv", ifc.data_valid, 1);
        set_addr(1, 9'h020);
        #1;
        chk("t1_raddr_track", ifc.ram_raddr, 9'h020);

        // 2: foreign latch_tail ignored, then owner completes
        ifc.cons_latch_tail = 4'b0100;
        tick();
        ifc.cons_latch_tail = '0;
        chk("t2_ign_gnt",   ifc.gnt, 4'b0010);
        chk("t2_ign_count", ifc.frame_count, 2);
        chk("t2_ign_tail",  ifc.frame_tail, 0);
        set_addr(1, 9'h023);
        ifc.cons_latch_tail = 4'b0010;
        tick();
        ifc.cons_latch_tail = '0;
        chk("t2_tail",  ifc.frame_tail, 9'h023);
        chk("t2_count", ifc.frame_count, 1);
        chk("t2_gnt0",  ifc.gnt, 0);
        chk("t2_raddr_tail", ifc.ram_raddr, 9'h023);
        tick();
        chk("t2_rr_gnt", ifc.gnt, 4'b0100);
        chk("t2_rr_fs",  ifc.frame_start, 4'b0100);
        chk("t2_raddr",  ifc.ram_raddr, 9'h200);
        tick();

        // 3: commit and completion together with count=1
        set_addr(2, 9'h0A0);
        ifc.cons_latch_tail = 4'b0100;
        ifc.frame_commit    = 1'b1;
        tick();
        ifc.cons_latch_tail = '0;
        ifc.frame_commit    = 1'b0;
        chk("t3_count", ifc.frame_count, 1);
        chk("t3_tail",  ifc.frame_tail, 9'h0A0);
        chk("t3_gnt0",  ifc.gnt, 0);

        // 4: consumer 1 wins (ptr=3 wraps), then drops req while owned
        tick();
        chk("t4_gnt", ifc.gnt, 4'b0010);
        tick();
        ifc.req = 4'b0100;
        tick();
        chk("t4_abort_gnt",   ifc.gnt, 0);
        chk("t4_abort_tail",  ifc.frame_tail, 9'h0A0);
        chk("t4_abort_count", ifc.frame_count, 1);
        tick();
        chk("t4_reoffer_gnt", ifc.gnt, 4'b0100);
        tick();
        set_addr(2, 9'h0B0);
        ifc.cons_latch_tail = 4'b0100;
        tick();
        ifc.cons_latch_tail = '0;
        chk("t4_done_count", ifc.frame_count, 0);
        chk("t4_done_tail",  ifc.frame_tail, 9'h0B0);
        ifc.req = 4'b0110;
        tick(); tick();
        chk("t4_no_frame_gnt", ifc.gnt, 0);

        // 5: saturate the frame counter
        ifc.req = '0;
        ifc.frame_commit = 1'b1;
        repeat (63) tick();
        ifc.frame_commit = 1'b0;
        chk("t5_count63", ifc.frame_count, 63);
        chk("t5_ovf0",    ifc.overflow, 0);
        ifc.frame_commit = 1'b1;
        tick();
        ifc.frame_commit = 1'b0;
        chk("t5_sat_count", ifc.frame_count, 63);
        chk("t5_ovf1",      ifc.overflow, 1);

        // 6: data_valid vs wr_ptr while consumer 0 owns the port
        set_addr(0, 9'h100);
        ifc.wr_ptr = 9'h1FF;
        ifc.req = 4'b0001;
        tick();
        chk("t6_gnt", ifc.gnt, 4'b0001);
        tick();
        chk("t6_dv1", ifc.data_valid, 1);
        ifc.wr_ptr = 9'h100;
        tick();
        chk("t6_dv_eq", ifc.data_valid, 0);
        ifc.wr_ptr = 9'h101;
        tick();
        chk("t6_dv_adv", ifc.data_valid, 1);
        ifc.cons_latch_tail = 4'b0001;
        tick();
        ifc.cons_latch_tail = '0;
        chk("t5_count62",  ifc.frame_count, 62);
        chk("t5_ovf_stky", ifc.overflow, 1);
        chk("t6_tail",     ifc.frame_tail, 9'h100);
        tick();
        chk("t6_dv_idle", ifc.data_valid, 0);

        // Reset mid-frame
        tick();
        chk("rst2_pre_gnt", ifc.gnt, 4'b0001);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst2_gnt",   ifc.gnt, 0);
        chk("rst2_tail",  ifc.frame_tail, 0);
        chk("rst2_count", ifc.frame_count, 0);
        chk("rst2_ovf",   ifc.overflow, 0);
        chk("rst2_dv",    ifc.data_valid, 0);
        tick();
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
